// File: rtl/neuron_pkg.sv
// Shared constants, FSM state type and width helpers for the streaming MAC neuron.
package neuron_pkg;

  localparam int LANES_DEF  = 28;
  localparam int CHUNKS_DEF = 28;
  localparam int W_W_DEF    = 19;
  localparam int P_W_DEF    = 10;
  localparam int ACC_W_DEF  = 40;
  localparam int OUT_W_DEF  = 26;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return r;
  endfunction

  function automatic int prod_w(input int w_w, input int p_w);
    return w_w + p_w + 1;
  endfunction

  function automatic int sum_w(input int w_w, input int p_w, input int lanes);
    return prod_w(w_w, p_w) + clog2(lanes);
  endfunction

  localparam int PROD_W = prod_w(W_W_DEF, P_W_DEF);
  localparam int SUM_W  = sum_w(W_W_DEF, P_W_DEF, LANES_DEF);

endpackage

// File: rtl/mac_lane_tree.sv
// LANES signed x unsigned multipliers (stage 1) followed by a registered
// lane-sum reduction (stage 2); each stage carries its own valid bit.
module mac_lane_tree
  import neuron_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int W_W   = W_W_DEF,
  parameter int P_W   = P_W_DEF
) (
  input  logic                                  clk,
  input  logic                                  GlobalReset,
  input  logic                                  valid_i,
  input  logic [LANES*W_W-1:0]                  weight_i,
  input  logic [LANES*P_W-1:0]                  pixel_i,
  output logic signed [sum_w(W_W, P_W, LANES)-1:0] sum_o,
  output logic                                  valid_o,
  output logic                                  pipe_busy_o
);

  localparam int PW = prod_w(W_W, P_W);
  localparam int SW = sum_w(W_W, P_W, LANES);

  logic signed [PW-1:0] prod_d [LANES];
  logic signed [PW-1:0] prod_q [LANES];
  logic signed [SW-1:0] sum_d;
  logic signed [SW-1:0] sum_q;
  logic                 v1_q;
  logic                 v2_q;

  // Pixels are zero-extended by one bit so the signed multiply treats them as unsigned.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod_d[k] = PW'($signed(weight_i[k*W_W +: W_W])) * PW'($signed({1'b0, pixel_i[k*P_W +: P_W]}));
    end
  end

  // NOTE: every variable written in always_comb gets a value on every path (here the
  // initial '0) so no latch is inferred.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < LANES; k++) begin
      sum_d = sum_d + SW'(prod_q[k]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // from pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= valid_i;
      v2_q <= v1_q;
    end
  end

  // NOTE: the wide data registers are not reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (valid_i) prod_q <= prod_d;
    if (v1_q)    sum_q  <= sum_d;
  end

  assign sum_o       = sum_q;
  assign valid_o     = v2_q;
  assign pipe_busy_o = v1_q | v2_q;

endmodule

// File: rtl/neuron_mac_stream.sv
// Streaming neuron: accepts CHUNKS chunks of LANES weight/pixel pairs, accumulates,
// adds bias, optionally applies ReLU and saturates to OUT_W.
module neuron_mac_stream
  import neuron_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int CHUNKS = CHUNKS_DEF,
  parameter int W_W    = W_W_DEF,
  parameter int P_W    = P_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic                    clk,
  input  logic                    GlobalReset,
  input  logic                    start,
  input  logic                    relu_en,
  input  logic signed [W_W-1:0]   bias,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*W_W-1:0]    weight_chunk,
  input  logic [LANES*P_W-1:0]    pixel_chunk,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    sat_flag,
  output logic                    busy
);

  localparam int SW    = sum_w(W_W, P_W, LANES);
  localparam int CNT_W = (CHUNKS > 1) ? clog2(CHUNKS) : 1;
  localparam int F_W   = ACC_W + 1;
  localparam logic signed [F_W-1:0] OUT_MAX = {{(F_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [F_W-1:0] OUT_MIN = {{(F_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  if (ACC_W < W_W + P_W + 1 + clog2(LANES * CHUNKS)) begin : g_acc_w_check
    $error("ACC_W too narrow for LANES*CHUNKS products");
  end

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [W_W-1:0]   bias_q;
  logic                    relu_q;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    sat_q, sat_d;
  logic signed [F_W-1:0]   f;

  logic signed [SW-1:0]    lane_sum;
  logic                    lane_sum_valid;
  logic                    pipe_busy;
  logic                    in_fire;
  logic                    last_chunk;
  logic                    start_fire;
  logic                    drain_done;

  mac_lane_tree #(
    .LANES (LANES),
    .W_W   (W_W),
    .P_W   (P_W)
  ) u_tree (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .valid_i     (in_fire),
    .weight_i    (weight_chunk),
    .pixel_i     (pixel_chunk),
    .sum_o       (lane_sum),
    .valid_o     (lane_sum_valid),
    .pipe_busy_o (pipe_busy)
  );

  assign in_fire    = in_valid && in_ready;
  assign last_chunk = (cnt_q == CNT_W'(CHUNKS - 1));
  assign start_fire = (state_q == IDLE) && start;
  assign drain_done = (state_q == DRAIN) && !pipe_busy;

  always_ff @(posedge clk) begin
    if (GlobalReset) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)                state_d = LOAD;
      LOAD:    if (in_fire && last_chunk) state_d = DRAIN;
      DRAIN:   if (!pipe_busy)            state_d = OUTPUT;
      OUTPUT:  if (out_ready)             state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == OUTPUT);
    busy      = (state_q != IDLE);
  end

  // Bias, ReLU and clamp; ReLU zeroing can never trip the clamp.
  always_comb begin
    f = F_W'(acc_q) + F_W'(bias_q);
    if (relu_q && f < 0) f = '0;
    sat_d      = 1'b0;
    out_data_d = OUT_W'(f);
    if (f > OUT_MAX) begin
      out_data_d = OUT_MAX[OUT_W-1:0];
      sat_d      = 1'b1;
    end else if (f < OUT_MIN) begin
      out_data_d = OUT_MIN[OUT_W-1:0];
      sat_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      bias_q     <= '0;
      relu_q     <= 1'b0;
      out_data_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      if (start_fire) begin
        bias_q <= bias;
        relu_q <= relu_en;
        acc_q  <= '0;
        cnt_q  <= '0;
      end else begin
        if (in_fire)        cnt_q <= cnt_q + CNT_W'(1);
        if (lane_sum_valid) acc_q <= acc_q + ACC_W'(lane_sum);
      end
      if (drain_done) begin
        out_data_q <= out_data_d;
        sat_q      <= sat_d;
      end
    end
  end

  assign out_data = out_data_q;
  assign sat_flag = sat_q;

endmodule

// File: tb/tb_neuron_mac_stream.sv
// Directed bench for neuron_mac_stream: constant vectors with hand-computed
// results, plus seeded random chunks checked against a behavioural sum.
module tb_neuron_mac_stream;

  localparam int LANES  = 28;
  localparam int CHUNKS = 28;
  localparam int W_W    = 19;
  localparam int P_W    = 10;
  localparam int ACC_W  = 40;
  localparam int OUT_W  = 26;
  localparam longint OMAX = 33554431;
  localparam longint OMIN = -33554432;

  logic                    clk = 1'b0;
  logic                    GlobalReset = 1'b1;
  logic                    start = 1'b0;
  logic                    relu_en = 1'b0;
  logic signed [W_W-1:0]   bias = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [LANES*W_W-1:0]    weight_chunk = '0;
  logic [LANES*P_W-1:0]    pixel_chunk = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [OUT_W-1:0] out_data;
  logic                    sat_flag;
  logic                    busy;

  int n_cmp = 0;
  int n_bad = 0;
  int w_arr [CHUNKS][LANES];
  int p_arr [CHUNKS][LANES];
  longint exp_d;
  longint exp_s;

  always #5 clk = ~clk;

  neuron_mac_stream #(
    .LANES (LANES), .CHUNKS (CHUNKS), .W_W (W_W), .P_W (P_W), .ACC_W (ACC_W), .OUT_W (OUT_W)
  ) dut (
    .clk          (clk),
    .GlobalReset  (GlobalReset),
    .start        (start),
    .relu_en      (relu_en),
    .bias         (bias),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .weight_chunk (weight_chunk),
    .pixel_chunk  (pixel_chunk),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .sat_flag     (sat_flag),
    .busy         (busy)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input int w, input int p);
    for (int c = 0; c < CHUNKS; c++)
      for (int k = 0; k < LANES; k++) begin
        w_arr[c][k] = w;
        p_arr[c][k] = p;
      end
  endtask

  task automatic fill_rand();
    for (int c = 0; c < CHUNKS; c++)
      for (int k = 0; k < LANES; k++) begin
        w_arr[c][k] = int'($urandom_range(0, 510)) - 255;
        p_arr[c][k] = int'($urandom_range(0, 1023));
      end
  endtask

  // Behavioural result: exact sum, bias, ReLU, clamp.
  task automatic model(input int bias_v, input bit relu, output longint d, output longint s);
    longint f;
    f = bias_v;
    for (int c = 0; c < CHUNKS; c++)
      for (int k = 0; k < LANES; k++)
        f += longint'(w_arr[c][k]) * longint'(p_arr[c][k]);
    if (relu && f < 0) f = 0;
    s = 0;
    d = f;
    if (f > OMAX) begin d = OMAX; s = 1; end
    else if (f < OMIN) begin d = OMIN; s = 1; end
  endtask

  task automatic start_eval(input int bias_v, input bit relu);
    start   = 1'b1;
    bias    = W_W'(bias_v);
    relu_en = relu;
    tick();
    start = 1'b0;
    check("load_ready", longint'(in_ready), 1);
  endtask

  // Streams the first n chunks; optionally pulses start while chunk start_at is offered.
  task automatic feed(input bit gaps, input int n, input int start_at);
    int  idx;
    int  cyc;
    bit  hs;
    bit  pulsed;
    idx = 0;
    cyc = 0;
    pulsed = 1'b0;
    while (idx < n && cyc < 1000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int k = 0; k < LANES; k++) begin
        weight_chunk[k*W_W +: W_W] = W_W'(w_arr[idx][k]);
        pixel_chunk[k*P_W +: P_W]  = P_W'(p_arr[idx][k]);
      end
      start = (!pulsed && idx == start_at);
      if (start) pulsed = 1'b1;
      hs = in_valid && in_ready;
      tick();
      cyc++;
      if (hs) idx++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (idx < n) check("feed_timeout", idx, n);
  endtask

  // Waits for the result, checks it (optionally across a stall), then consumes it.
  task automatic collect(input string tag, input int hold, input longint d, input longint s);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!out_valid) check({tag, "_valid_timeout"}, 0, 1);
    check({tag, "_data"}, longint'(out_data), d);
    check({tag, "_sat"}, longint'(sat_flag), s);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_ready"}, longint'(in_ready), 0);
      check({tag, "_hold_data"}, longint'(out_data), d);
      check({tag, "_hold_valid"}, longint'(out_valid), 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, longint'(out_valid), 0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_sat", longint'(sat_flag), 0);
    check("rst_busy", longint'(busy), 0);
    GlobalReset = 1'b0;
    tick();

    // Ones: 784, and exact E+3 latency
    fill_const(1, 1);
    start_eval(0, 1'b0);
    feed(1'b0, CHUNKS, -1);
    check("ones_drain_ready", longint'(in_ready), 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("ones_lat_e%0d", i), longint'(out_valid), (i == 3) ? 1 : 0);
    end
    collect("ones", 0, 784, 0);

    // Zero weights with negative bias, without and with ReLU (back-to-back starts)
    fill_const(0, 7);
    start_eval(-5, 1'b0);
    feed(1'b0, CHUNKS, -1);
    collect("bias_neg", 0, -5, 0);
    start_eval(-5, 1'b1);
    feed(1'b0, CHUNKS, -1);
    collect("bias_relu", 0, 0, 0);

    // Saturation at both rails
    fill_const(262143, 1023);
    start_eval(0, 1'b0);
    feed(1'b0, CHUNKS, -1);
    collect("sat_pos", 0, 33554431, 1);
    fill_const(-262144, 1023);
    start_eval(0, 1'b0);
    feed(1'b0, CHUNKS, -1);
    collect("sat_neg", 0, -33554432, 1);

    // Random data, bursty valid, output stalled 10 cycles
    fill_rand();
    model(1234, 1'b0, exp_d, exp_s);
    start_eval(1234, 1'b0);
    feed(1'b1, CHUNKS, -1);
    check("rand_drain_ready", longint'(in_ready), 0);
    collect("rand_stall", 10, exp_d, exp_s);

    // Reset mid-evaluation, then a clean evaluation
    fill_const(1, 1);
    start_eval(0, 1'b0);
    feed(1'b0, 10, -1);
    GlobalReset = 1'b1;
    tick();
    GlobalReset = 1'b0;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_in_ready", longint'(in_ready), 0);
    start_eval(0, 1'b0);
    feed(1'b1, CHUNKS, -1);
    collect("after_rst", 0, 784, 0);

    // start pulsed during LOAD is ignored; followed by a back-to-back evaluation
    fill_rand();
    model(-20000, 1'b1, exp_d, exp_s);
    start_eval(-20000, 1'b1);
    feed(1'b1, CHUNKS, 5);
    collect("start_in_load", 0, exp_d, exp_s);
    fill_const(3, 2);
    start_eval(100, 1'b0);
    feed(1'b0, CHUNKS, -1);
    collect("b2b", 0, 4804, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
